// File: rtl/instr_decode_reg_pkg.sv
// Shared types and constants for the MIPS instruction decode register.
package instr_decode_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ITYPE_R = 2'd0,
        ITYPE_J = 2'd1,
        ITYPE_I = 2'd2
    } itype_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

endpackage

// File: rtl/instr_decode_reg_if.sv
// Upstream instruction handshake plus the decoded head-entry outputs.
interface instr_decode_reg_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      opcode;
    logic [5:0]      func;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [25:0]     imm26;
    logic [15:0]     imm16;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] imm_zext;
    logic [XLEN-1:0] imm_lui;
    logic [1:0]      itype;
    logic [PC_W-1:0] pc_out;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] j_target;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, opcode, func, rs, rt, rd, shamt, imm26, imm16,
               imm_sext, imm_zext, imm_lui, itype, pc_out, br_target, j_target
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, opcode, func, rs, rt, rd, shamt, imm26, imm16,
               imm_sext, imm_zext, imm_lui, itype, pc_out, br_target, j_target
    );
endinterface

// File: rtl/instr_decode_reg_fields.sv
// Pure combinational field slicing, immediate extension and class decode of one MIPS word.
module instr_fields
    import instr_decode_reg_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [5:0]      opcode_o,
    output logic [5:0]      func_o,
    output logic [4:0]      rs_o,
    output logic [4:0]      rt_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      shamt_o,
    output logic [25:0]     imm26_o,
    output logic [15:0]     imm16_o,
    output logic [XLEN-1:0] imm_sext_o,
    output logic [XLEN-1:0] imm_zext_o,
    output logic [XLEN-1:0] imm_lui_o,
    output itype_e          itype_o
);
    assign opcode_o = instr_i[31:26];
    assign rs_o     = instr_i[25:21];
    assign rt_o     = instr_i[20:16];
    assign rd_o     = instr_i[15:11];
    assign shamt_o  = instr_i[10:6];
    assign func_o   = instr_i[5:0];
    assign imm26_o  = instr_i[25:0];
    assign imm16_o  = instr_i[15:0];

    // Widening a signed value replicates its top bit, which gives sign-extension for any XLEN.
    assign imm_sext_o = XLEN'($signed(instr_i[15:0]));
    assign imm_zext_o = XLEN'(instr_i[15:0]);
    assign imm_lui_o  = XLEN'($signed({instr_i[15:0], 16'h0000}));

    // NOTE: default assignment first so every path drives itype_o and no latch is inferred.
    always_comb begin
        itype_o = ITYPE_I;
        if (instr_i[31:26] == OP_RTYPE) begin
            itype_o = ITYPE_R;
        end else if (instr_i[31:26] == OP_J || instr_i[31:26] == OP_JAL) begin
            itype_o = ITYPE_J;
        end
    end
endmodule

// File: rtl/instr_decode_reg.sv
// Two-entry skid buffer of {instr, pc} that presents the decoded head entry and its branch/jump targets.
module instr_decode_reg
    import instr_decode_reg_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    instr_decode_reg_if.slave bus
);
    state_e          state_q;
    logic            in_ready_q;
    logic [31:0]     head_instr_q;
    logic [31:0]     skid_instr_q;
    logic [PC_W-1:0] head_pc_q;
    logic [PC_W-1:0] skid_pc_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = (state_q != EMPTY) & bus.out_ready;

    // in_ready is a flop so upstream never sees a combinational path from out_ready.
    // NOTE: storage is cleared on reset because the field outputs must read 0 while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else if (flush) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            unique case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        head_instr_q <= bus.in_instr;
                        head_pc_q    <= bus.in_pc;
                        state_q      <= ONE;
                    end
                end
                ONE: begin
                    in_ready_q <= 1'b1;
                    if (in_fire && !out_fire) begin
                        skid_instr_q <= bus.in_instr;
                        skid_pc_q    <= bus.in_pc;
                        state_q      <= TWO;
                        in_ready_q   <= 1'b0;
                    end else if (in_fire && out_fire) begin
                        head_instr_q <= bus.in_instr;
                        head_pc_q    <= bus.in_pc;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    in_ready_q <= 1'b0;
                    if (out_fire) begin
                        head_instr_q <= skid_instr_q;
                        head_pc_q    <= skid_pc_q;
                        state_q      <= ONE;
                        in_ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.pc_out    = head_pc_q;

    logic [5:0]      opcode_w;
    logic [5:0]      func_w;
    logic [4:0]      rs_w;
    logic [4:0]      rt_w;
    logic [4:0]      rd_w;
    logic [4:0]      shamt_w;
    logic [25:0]     imm26_w;
    logic [15:0]     imm16_w;
    logic [XLEN-1:0] imm_sext_w;
    logic [XLEN-1:0] imm_zext_w;
    logic [XLEN-1:0] imm_lui_w;
    itype_e          itype_w;

    instr_fields #(.XLEN(XLEN)) u_fields (
        .instr_i    (head_instr_q),
        .opcode_o   (opcode_w),
        .func_o     (func_w),
        .rs_o       (rs_w),
        .rt_o       (rt_w),
        .rd_o       (rd_w),
        .shamt_o    (shamt_w),
        .imm26_o    (imm26_w),
        .imm16_o    (imm16_w),
        .imm_sext_o (imm_sext_w),
        .imm_zext_o (imm_zext_w),
        .imm_lui_o  (imm_lui_w),
        .itype_o    (itype_w)
    );

    assign bus.opcode   = opcode_w;
    assign bus.func     = func_w;
    assign bus.rs       = rs_w;
    assign bus.rt       = rt_w;
    assign bus.rd       = rd_w;
    assign bus.shamt    = shamt_w;
    assign bus.imm26    = imm26_w;
    assign bus.imm16    = imm16_w;
    assign bus.imm_sext = imm_sext_w;
    assign bus.imm_zext = imm_zext_w;
    assign bus.imm_lui  = imm_lui_w;
    assign bus.itype    = itype_w;

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br_off;

    // Targets wrap modulo 2^PC_W; the jump keeps the upper PC bits above bit 27 of pc+4.
    assign pc_plus4      = head_pc_q + PC_W'(4);
    assign br_off        = PC_W'($signed({head_instr_q[15:0], 2'b00}));
    assign bus.br_target = pc_plus4 + br_off;
    assign bus.j_target  = (pc_plus4 & ~PC_W'(28'hFFF_FFFF)) | PC_W'({head_instr_q[25:0], 2'b00});
endmodule

// File: tb/tb_instr_decode_reg.sv
// Directed bench for instr_decode_reg: decode values, skid back-pressure, flush, async reset, XLEN=64.
module tb_instr_decode_reg;
    logic clk;
    logic rst;
    logic flush;
    logic flush64;

    int n_checks = 0;
    int n_fail   = 0;

    instr_decode_reg_if #(.XLEN(32), .PC_W(32)) bus32 ();
    instr_decode_reg_if #(.XLEN(64), .PC_W(32)) bus64 ();

    instr_decode_reg #(.XLEN(32), .PC_W(32)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus32)
    );

    instr_decode_reg #(.XLEN(64), .PC_W(32)) u_dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush64),
        .bus   (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive32(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus32.in_valid = v;
        bus32.in_instr = instr;
        bus32.in_pc    = pc;
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        flush64 = 1'b0;
        drive32(1'b0, 32'h0, 32'h0);
        bus32.out_ready = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.in_instr  = 32'h0;
        bus64.in_pc     = 32'h0;
        bus64.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus32.out_valid, 0);
        check("rst_in_ready", bus32.in_ready, 0);
        check("rst_opcode", bus32.opcode, 0);
        check("rst_pc_out", bus32.pc_out, 0);
        rst = 1'b0;
        #1;
        check("in_ready_before_edge", bus32.in_ready, 0);
        @(negedge clk);
        check("in_ready_after_rst", bus32.in_ready, 1);
        check("empty_out_valid", bus32.out_valid, 0);

        // addi $t0,$t0,-4 on the 32-bit DUT, lui on the 64-bit DUT
        drive32(1'b1, 32'h2108FFFC, 32'h00400000);
        bus32.out_ready = 1'b1;
        bus64.in_valid  = 1'b1;
        bus64.in_instr  = 32'h3C08_8000;
        bus64.out_ready = 1'b1;
        @(negedge clk);
        check("addi_out_valid", bus32.out_valid, 1);
        check("addi_opcode", bus32.opcode, 6'h08);
        check("addi_rs", bus32.rs, 8);
        check("addi_rt", bus32.rt, 8);
        check("addi_imm_sext", bus32.imm_sext, 32'hFFFFFFFC);
        check("addi_imm_zext", bus32.imm_zext, 32'h0000FFFC);
        check("addi_itype", bus32.itype, 2);
        check("addi_br_target", bus32.br_target, 32'h003FFFF4);
        check("addi_pc_out", bus32.pc_out, 32'h00400000);
        check("lui64_imm_lui", bus64.imm_lui, 64'hFFFFFFFF80000000);
        check("lui64_imm_sext", bus64.imm_sext, 64'hFFFFFFFFFFFF8000);
        check("lui64_imm_zext", bus64.imm_zext, 64'h0000000000008000);
        check("lui64_rt", bus64.rt, 8);
        bus64.in_valid = 1'b0;

        // jal: accepted in ONE together with the addi being consumed
        drive32(1'b1, 32'h0C100010, 32'h00400008);
        @(negedge clk);
        check("jal_out_valid", bus32.out_valid, 1);
        check("jal_itype", bus32.itype, 1);
        check("jal_opcode", bus32.opcode, 6'h03);
        check("jal_imm26", bus32.imm26, 26'h0100010);
        check("jal_j_target", bus32.j_target, 32'h00400040);
        drive32(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("drain_out_valid", bus32.out_valid, 0);

        // Back-pressure: A, B fill the buffer, C is held off
        bus32.out_ready = 1'b0;
        drive32(1'b1, 32'h012A4020, 32'h00001000);
        @(negedge clk);
        check("A_in_ready", bus32.in_ready, 1);
        check("A_pc_out", bus32.pc_out, 32'h00001000);
        check("A_itype", bus32.itype, 0);
        check("A_rd", bus32.rd, 8);
        check("A_func", bus32.func, 6'h20);
        drive32(1'b1, 32'h08000400, 32'h00001004);
        @(negedge clk);
        check("AB_in_ready", bus32.in_ready, 0);
        check("AB_pc_out", bus32.pc_out, 32'h00001000);
        drive32(1'b1, 32'h8D090004, 32'h00001008);
        @(negedge clk);
        check("C_held_in_ready", bus32.in_ready, 0);
        check("C_held_pc_out", bus32.pc_out, 32'h00001000);
        bus32.out_ready = 1'b1;
        @(negedge clk);
        check("B_pc_out", bus32.pc_out, 32'h00001004);
        check("B_opcode", bus32.opcode, 6'h02);
        check("B_in_ready", bus32.in_ready, 1);
        @(negedge clk);
        check("C_out_valid", bus32.out_valid, 1);
        check("C_pc_out", bus32.pc_out, 32'h00001008);
        check("C_opcode", bus32.opcode, 6'h23);
        check("C_imm_sext", bus32.imm_sext, 32'h00000004);
        drive32(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("C_drained", bus32.out_valid, 0);

        // Flush in TWO with a simultaneous input
        bus32.out_ready = 1'b0;
        drive32(1'b1, 32'h21080001, 32'h00002000);
        @(negedge clk);
        drive32(1'b1, 32'h21080002, 32'h00002004);
        @(negedge clk);
        check("pre_flush_in_ready", bus32.in_ready, 0);
        drive32(1'b1, 32'h3C081234, 32'h00002008);
        flush = 1'b1;
        @(negedge clk);
        check("flush_out_valid", bus32.out_valid, 0);
        check("flush_in_ready", bus32.in_ready, 1);
        flush = 1'b0;
        drive32(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("post_flush_out_valid", bus32.out_valid, 0);
        drive32(1'b1, 32'h2108FFFC, 32'h00003000);
        @(negedge clk);
        check("G_pc_out", bus32.pc_out, 32'h00003000);
        check("G_out_valid", bus32.out_valid, 1);
        drive32(1'b0, 32'h0, 32'h0);

        // Asynchronous reset between edges while in ONE
        #1 rst = 1'b1;
        #1;
        check("async_rst_out_valid", bus32.out_valid, 0);
        check("async_rst_opcode", bus32.opcode, 0);
        check("async_rst_pc_out", bus32.pc_out, 0);
        check("async_rst_in_ready", bus32.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rerst_in_ready", bus32.in_ready, 1);
        check("rerst_out_valid", bus32.out_valid, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
